// File: rtl/neuron_mac.sv
// neuron_mac: windowed multiply-accumulate with bias add and hard-sigmoid activation,
// presented on a valid/ready output backed by a single-entry overwrite buffer.
module neuron_mac #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sum_finish,
    input  logic [DATA_W-1:0]   din,
    input  logic [WEIGHT_W-1:0] win,
    input  logic [ACC_W-1:0]    bias,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam int ACT_W  = ACC_W + 2;

    // stage P
    logic signed [PROD_W-1:0] din_x, win_x;
    logic [PROD_W-1:0]        prod_d, prod_q;
    logic                     fin_d, fin_q;

    // stage A
    logic [ACC_W-1:0]         prod_ext, acc_d, acc_q;
    logic [SUM_W-1:0]         sum_d, sum_q;
    logic                     sum_v_d, sum_v_q;
    logic                     first_d, first_q;

    // stage O
    logic signed [SUM_W-1:0]  sum_s, x_s;
    logic [ACT_W-1:0]         y_full;
    logic [OUT_W-1:0]         act_y;
    logic [OUT_W-1:0]         out_data_d, out_data_q;
    logic                     out_valid_d, out_valid_q;
    logic                     overrun_d, overrun_q;

    // Operands are widened to the product width so the multiply is exact.
    always_comb begin
        din_x  = {{WEIGHT_W{din[DATA_W-1]}}, din};
        win_x  = {{DATA_W{win[WEIGHT_W-1]}}, win};
        prod_d = din_x * win_x;
        fin_d  = sum_finish;
    end

    // The sample paired with sum_finish opens the next window, so it seeds acc.
    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        acc_d    = acc_q + prod_ext;
        sum_d    = sum_q;
        sum_v_d  = 1'b0;
        first_d  = first_q;
        if (fin_q) begin
            sum_d   = {acc_q[ACC_W-1], acc_q} + {bias[ACC_W-1], bias};
            acc_d   = prod_ext;
            sum_v_d = ~first_q;
            first_d = 1'b0;
        end
    end

    // Hard sigmoid: floor-shift, recentre at mid-scale, saturate to [0, 2^OUT_W-1].
    always_comb begin
        sum_s  = sum_q;
        x_s    = sum_s >>> SHIFT;
        y_full = {x_s[SUM_W-1], x_s} + ACT_W'(1 << (OUT_W-1));
        if (y_full[ACT_W-1])
            act_y = '0;
        else if (|y_full[ACT_W-2:OUT_W])
            act_y = '1;
        else
            act_y = y_full[OUT_W-1:0];
    end

    // Single-entry buffer; a fresh result always wins over an unconsumed one.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (sum_v_q) begin
            out_data_d  = act_y;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready)
                overrun_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q      <= '0;
            fin_q       <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_v_q     <= 1'b0;
            first_q     <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            fin_q       <= fin_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_v_q     <= sum_v_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: two instances (SHIFT=0 and SHIFT=2) share stimulus; a window
// model pushes expected activations to a queue that is popped when each result is due.
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sum_finish = 1'b0;
    logic out_ready = 1'b1;
    logic signed [7:0]  din = '0;
    logic signed [7:0]  win = '0;
    logic signed [23:0] bias = '0;
    logic [7:0] od0, od2;
    logic ov0, ov2, orun0, orun2;

    always #5 clk = ~clk;

    neuron_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(0), .OUT_W(8)) dut0 (
        .clk(clk), .rst(rst), .sum_finish(sum_finish), .din(din), .win(win), .bias(bias),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .overrun(orun0));

    neuron_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(2), .OUT_W(8)) dut2 (
        .clk(clk), .rst(rst), .sum_finish(sum_finish), .din(din), .win(win), .bias(bias),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .overrun(orun2));

    typedef struct {
        int y0;
        int y2;
        int due;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    bit     strict = 1'b0;
    longint m_acc = 0;
    longint m_sum = 0;
    bit     m_first = 1'b1;
    bit     m_pend = 1'b0;

    function automatic int act(input longint s, input int sh);
        longint x;
        x = (s >>> sh) + 128;
        if (x < 0) return 0;
        if (x > 255) return 255;
        return int'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs being driven, then check after the edge.
    task automatic tick();
        exp_t e;
        if (!rst) begin
            m_acc = 0; m_first = 1'b1; m_pend = 1'b0; sb.delete();
        end else begin
            if (m_pend) begin
                e.y0 = act(m_sum + longint'(bias), 0);
                e.y2 = act(m_sum + longint'(bias), 2);
                e.due = cyc + 2;
                sb.push_back(e);
                m_pend = 1'b0;
            end
            if (sum_finish) begin
                if (!m_first) begin
                    m_pend = 1'b1;
                    m_sum = m_acc;
                end
                m_first = 1'b0;
                m_acc = longint'(din) * longint'(win);
            end else begin
                m_acc = m_acc + longint'(din) * longint'(win);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("valid0", ov0, 1);
            chk("valid2", ov2, 1);
            chk("data0", od0, e.y0);
            chk("data2", od2, e.y2);
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("sb_missed", e.due, cyc);
        end else if (strict) begin
            chk("idle_valid0", ov0, 0);
            chk("idle_valid2", ov2, 0);
        end
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic window(input int n);
        sum_finish = 1'b1;
        tick();
        sum_finish = 1'b0;
        for (int i = 1; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data0"}, od0, 0);
        chk({tag, "_valid0"}, ov0, 0);
        chk({tag, "_ovr0"}, orun0, 0);
        chk({tag, "_data2"}, od2, 0);
        chk({tag, "_valid2"}, ov2, 0);
        chk({tag, "_ovr2"}, orun2, 0);
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        samples(3);
        chk_zero("rst");

        // din=1,win=1: partial first window discarded, then 178 / 140 per window
        rst = 1'b1; strict = 1'b1; out_ready = 1'b1;
        din = 8'sd1; win = 8'sd1; bias = '0;
        samples(10);
        window(50);
        window(50);
        window(50);

        // extreme products: no wrap, saturate low and high
        din = -8'sd128; win = 8'sd127;
        window(50);
        din = 8'sd127;
        window(50);

        // negative bias: SHIFT=2 gives floor(-150/4)+128 = 90, SHIFT=0 clamps to 0
        din = 8'sd1; win = 8'sd1;
        window(25);
        bias = -24'sd200;
        samples(25);
        window(3);
        bias = '0;
        samples(47);

        // hold first result, then accept exactly as the next result lands
        strict = 1'b0; out_ready = 1'b0; din = 8'sd2;
        window(50);
        din = 8'sd1;
        window(2);
        out_ready = 1'b1;
        tick();
        chk("same_cycle_ovr0", orun0, 0);
        chk("same_cycle_ovr2", orun2, 0);
        tick();
        chk("drain_valid0", ov0, 0);
        chk("drain_valid2", ov2, 0);
        strict = 1'b1;
        samples(46);

        // backpressure over two windows forces an overwrite
        strict = 1'b0; out_ready = 1'b0;
        window(50);
        window(3);
        chk("overrun_set0", orun0, 1);
        chk("overrun_set2", orun2, 1);
        out_ready = 1'b1;
        tick();
        chk("overrun_pop_valid0", ov0, 0);
        chk("overrun_pop_valid2", ov2, 0);
        chk("overrun_sticky0", orun0, 1);
        chk("overrun_sticky2", orun2, 1);
        strict = 1'b1;
        samples(46);

        // reset at sample 20: next window discarded, following one is 178
        window(20);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_zero("midrst");
        samples(29);
        window(50);
        window(50);
        window(5);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
